// File: rtl/axi_rd_arbiter.sv
// axi_rd_arbiter: shares one AXI4 read port between IFU and LSU with
// round-robin arbitration and one transaction outstanding.
// Ports: clk, rstn (sync, active-low);
//   ifu_req_*/lsu_req_*: valid/ready request (addr, size);
//   ifu_rsp_*/lsu_rsp_*: one-cycle response pulse (data, err);
//   AR*/R*: AXI4 read address/data channels; proto_err: sticky bad-beat flag.
module axi_rd_arbiter #(
  parameter int ADDR_W = 64,
  parameter int DATA_W = 64,
  parameter int ID_W   = 4,
  parameter int IFU_ID = 0,
  parameter int LSU_ID = 1
) (
  input  logic              clk,
  input  logic              rstn,
  input  logic              ifu_req_valid,
  output logic              ifu_req_ready,
  input  logic [ADDR_W-1:0] ifu_req_addr,
  input  logic [2:0]        ifu_req_size,
  output logic              ifu_rsp_valid,
  output logic [DATA_W-1:0] ifu_rsp_data,
  output logic              ifu_rsp_err,
  input  logic              lsu_req_valid,
  output logic              lsu_req_ready,
  input  logic [ADDR_W-1:0] lsu_req_addr,
  input  logic [2:0]        lsu_req_size,
  output logic              lsu_rsp_valid,
  output logic [DATA_W-1:0] lsu_rsp_data,
  output logic              lsu_rsp_err,
  output logic [ID_W-1:0]   ARID,
  output logic [ADDR_W-1:0] ARADDR,
  output logic [7:0]        ARLEN,
  output logic [2:0]        ARSIZE,
  output logic [1:0]        ARBURST,
  output logic [2:0]        ARPROT,
  output logic              ARVALID,
  input  logic              ARREADY,
  input  logic [ID_W-1:0]   RID,
  input  logic [DATA_W-1:0] RDATA,
  input  logic [1:0]        RRESP,
  input  logic              RLAST,
  input  logic              RVALID,
  output logic              RREADY,
  output logic              proto_err
);

  typedef enum logic [1:0] {IDLE, AR, R} state_t;

  localparam logic [ID_W-1:0] IFU_IDV = ID_W'(IFU_ID);
  localparam logic [ID_W-1:0] LSU_IDV = ID_W'(LSU_ID);

  state_t          state;
  state_t          state_nxt;
  logic            last_lsu;
  logic            own_lsu;
  logic            gnt_ifu;
  logic            gnt_lsu;
  logic            acc_ifu;
  logic            acc_lsu;
  logic [ID_W-1:0] own_id;
  logic            beat_ok;

  // LSU wins when alone, or when contended and IFU had the last grant.
  assign gnt_lsu = lsu_req_valid &&
                   (!ifu_req_valid || !last_lsu);
  assign gnt_ifu = ifu_req_valid && !gnt_lsu;

  assign ifu_req_ready = rstn && (state == IDLE) && gnt_ifu;
  assign lsu_req_ready = rstn && (state == IDLE) && gnt_lsu;
  assign acc_ifu = ifu_req_valid && ifu_req_ready;
  assign acc_lsu = lsu_req_valid && lsu_req_ready;

  assign own_id  = own_lsu ? LSU_IDV : IFU_IDV;
  assign RREADY  = rstn && (state == R);
  assign beat_ok = RREADY && RVALID &&
                   (RID == own_id) && RLAST;

  assign ARLEN   = 8'd0;
  assign ARBURST = 2'b01;

  always_ff @(posedge clk) begin
    if (!rstn) state <= IDLE;
    else       state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    unique case (state)
      IDLE:    if (acc_ifu || acc_lsu) state_nxt = AR;
      AR:      if (ARREADY) state_nxt = R;
      R:       if (beat_ok) state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!rstn) begin
      last_lsu      <= 1'b0;
      own_lsu       <= 1'b0;
      ARVALID       <= 1'b0;
      ARID          <= '0;
      ARADDR        <= '0;
      ARSIZE        <= '0;
      ARPROT        <= '0;
      ifu_rsp_valid <= 1'b0;
      ifu_rsp_data  <= '0;
      ifu_rsp_err   <= 1'b0;
      lsu_rsp_valid <= 1'b0;
      lsu_rsp_data  <= '0;
      lsu_rsp_err   <= 1'b0;
      proto_err     <= 1'b0;
    end else begin
      ifu_rsp_valid <= 1'b0;
      lsu_rsp_valid <= 1'b0;
      if (acc_ifu || acc_lsu) begin
        own_lsu  <= acc_lsu;
        last_lsu <= acc_lsu;
        ARVALID  <= 1'b1;
        ARID     <= acc_lsu ? LSU_IDV : IFU_IDV;
        ARADDR   <= acc_lsu ? lsu_req_addr : ifu_req_addr;
        ARSIZE   <= acc_lsu ? lsu_req_size : ifu_req_size;
        ARPROT   <= acc_lsu ? 3'b000 : 3'b100;
      end else if (ARVALID && ARREADY) begin
        ARVALID <= 1'b0;
      end
      if (beat_ok) begin
        if (own_lsu) begin
          lsu_rsp_valid <= 1'b1;
          lsu_rsp_data  <= RDATA;
          lsu_rsp_err   <= (RRESP != 2'b00);
        end else begin
          ifu_rsp_valid <= 1'b1;
          ifu_rsp_data  <= RDATA;
          ifu_rsp_err   <= (RRESP != 2'b00);
        end
      end
      // Any beat that is not the expected last beat is a protocol error,
      // including stray beats outside the R phase.
      if (RVALID && !beat_ok) proto_err <= 1'b1;
    end
  end

endmodule

// File: tb/tb_axi_rd_arbiter.sv
// tb_axi_rd_arbiter: randomized requesters and AXI slave checked
// cycle by cycle against a transaction-level reference model.
module tb_axi_rd_arbiter;

  localparam int AW   = 64;
  localparam int DW   = 64;
  localparam int IW   = 4;
  localparam int NCYC = 4000;

  logic          clk = 1'b0;
  logic          rstn = 1'b0;
  logic          ifu_req_valid = 1'b0;
  logic          ifu_req_ready;
  logic [AW-1:0] ifu_req_addr = '0;
  logic [2:0]    ifu_req_size = '0;
  logic          ifu_rsp_valid;
  logic [DW-1:0] ifu_rsp_data;
  logic          ifu_rsp_err;
  logic          lsu_req_valid = 1'b0;
  logic          lsu_req_ready;
  logic [AW-1:0] lsu_req_addr = '0;
  logic [2:0]    lsu_req_size = '0;
  logic          lsu_rsp_valid;
  logic [DW-1:0] lsu_rsp_data;
  logic          lsu_rsp_err;
  logic [IW-1:0] ARID;
  logic [AW-1:0] ARADDR;
  logic [7:0]    ARLEN;
  logic [2:0]    ARSIZE;
  logic [1:0]    ARBURST;
  logic [2:0]    ARPROT;
  logic          ARVALID;
  logic          ARREADY = 1'b0;
  logic [IW-1:0] RID = '0;
  logic [DW-1:0] RDATA = '0;
  logic [1:0]    RRESP = '0;
  logic          RLAST = 1'b0;
  logic          RVALID = 1'b0;
  logic          RREADY;
  logic          proto_err;

  always #5 clk = ~clk;

  axi_rd_arbiter #(
    .ADDR_W(AW), .DATA_W(DW), .ID_W(IW),
    .IFU_ID(0), .LSU_ID(1)
  ) dut (
    .clk(clk), .rstn(rstn),
    .ifu_req_valid(ifu_req_valid), .ifu_req_ready(ifu_req_ready),
    .ifu_req_addr(ifu_req_addr), .ifu_req_size(ifu_req_size),
    .ifu_rsp_valid(ifu_rsp_valid), .ifu_rsp_data(ifu_rsp_data),
    .ifu_rsp_err(ifu_rsp_err),
    .lsu_req_valid(lsu_req_valid), .lsu_req_ready(lsu_req_ready),
    .lsu_req_addr(lsu_req_addr), .lsu_req_size(lsu_req_size),
    .lsu_rsp_valid(lsu_rsp_valid), .lsu_rsp_data(lsu_rsp_data),
    .lsu_rsp_err(lsu_rsp_err),
    .ARID(ARID), .ARADDR(ARADDR), .ARLEN(ARLEN), .ARSIZE(ARSIZE),
    .ARBURST(ARBURST), .ARPROT(ARPROT), .ARVALID(ARVALID),
    .ARREADY(ARREADY),
    .RID(RID), .RDATA(RDATA), .RRESP(RRESP), .RLAST(RLAST),
    .RVALID(RVALID), .RREADY(RREADY),
    .proto_err(proto_err)
  );

  int n_cmp = 0;
  int n_bad = 0;

  task automatic chk(input string tag,
                     input logic [63:0] got,
                     input logic [63:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  // Reference model: one outstanding transaction described by owner,
  // whether its address phase is still open, and the AR fields.
  bit            busy;
  bit            ar_open;
  bit            own_lsu;
  bit            last_lsu;
  bit            m_perr;
  bit            p_ifu;
  bit            p_lsu;
  logic [AW-1:0] m_addr;
  logic [IW-1:0] m_id;
  logic [2:0]    m_size;
  logic [2:0]    m_prot;
  logic [DW-1:0] d_ifu;
  logic [DW-1:0] d_lsu;
  bit            e_ifu;
  bit            e_lsu;
  int            rdly;
  bit            acc_i;
  bit            acc_l;

  task automatic model_reset();
    busy = 0; ar_open = 0; own_lsu = 0; last_lsu = 0;
    m_perr = 0; p_ifu = 0; p_lsu = 0;
    m_addr = '0; m_id = '0; m_size = '0; m_prot = '0;
    d_ifu = '0; d_lsu = '0; e_ifu = 0; e_lsu = 0;
    rdly = 0; acc_i = 0; acc_l = 0;
  endtask

  initial begin
    bit            do_rst;
    bit            win_lsu;
    bit            any;
    logic [IW-1:0] oid;
    model_reset();
    for (int cyc = 0; cyc < NCYC; cyc++) begin
      @(negedge clk);
      chk("arvalid", 64'(ARVALID), 64'(ar_open));
      chk("araddr", ARADDR, m_addr);
      chk("arid", 64'(ARID), 64'(m_id));
      chk("arsize", 64'(ARSIZE), 64'(m_size));
      chk("arprot", 64'(ARPROT), 64'(m_prot));
      chk("arlen", 64'(ARLEN), 64'd0);
      chk("arburst", 64'(ARBURST), 64'd1);
      chk("ifu_rsp_valid", 64'(ifu_rsp_valid), 64'(p_ifu));
      chk("lsu_rsp_valid", 64'(lsu_rsp_valid), 64'(p_lsu));
      chk("ifu_rsp_data", ifu_rsp_data, d_ifu);
      chk("lsu_rsp_data", lsu_rsp_data, d_lsu);
      chk("ifu_rsp_err", 64'(ifu_rsp_err), 64'(e_ifu));
      chk("lsu_rsp_err", 64'(lsu_rsp_err), 64'(e_lsu));
      chk("proto_err", 64'(proto_err), 64'(m_perr));
      p_ifu = 0;
      p_lsu = 0;

      do_rst = (cyc < 2) ||
               (busy && !ar_open && $urandom_range(0, 39) == 0);
      rstn = !do_rst;
      oid = own_lsu ? 4'd1 : 4'd0;

      if (acc_i) ifu_req_valid = 1'b0;
      if (acc_l) lsu_req_valid = 1'b0;
      acc_i = 0;
      acc_l = 0;
      RVALID = 1'b0;
      RLAST  = 1'b0;
      if (do_rst) begin
        ifu_req_valid = 1'b0;
        lsu_req_valid = 1'b0;
        ARREADY = 1'b0;
      end else begin
        if (!ifu_req_valid && $urandom_range(0, 2) != 0) begin
          ifu_req_valid = 1'b1;
          ifu_req_addr  = {$urandom, $urandom};
          ifu_req_size  = 3'($urandom_range(0, 7));
        end
        if (!lsu_req_valid && $urandom_range(0, 2) != 0) begin
          lsu_req_valid = 1'b1;
          lsu_req_addr  = {$urandom, $urandom};
          lsu_req_size  = 3'($urandom_range(0, 7));
        end
        ARREADY = 1'($urandom_range(0, 1));
        if (busy && !ar_open) begin
          if (rdly > 0) begin
            rdly--;
          end else begin
            RVALID = 1'b1;
            RDATA  = {$urandom, $urandom};
            RRESP  = 2'($urandom_range(0, 3));
            RID    = oid;
            RLAST  = 1'b1;
            if ($urandom_range(0, 4) == 0) begin
              if ($urandom_range(0, 1) == 0)
                RID = oid ^ 4'($urandom_range(1, 15));
              else
                RLAST = 1'b0;
            end
          end
        end
      end

      #1;
      if (do_rst) begin
        model_reset();
      end else begin
        any = ifu_req_valid || lsu_req_valid;
        if (ifu_req_valid && lsu_req_valid) win_lsu = !last_lsu;
        else                                win_lsu = lsu_req_valid;
        chk("ifu_req_ready", 64'(ifu_req_ready),
            64'(!busy && any && !win_lsu));
        chk("lsu_req_ready", 64'(lsu_req_ready),
            64'(!busy && any && win_lsu));
        chk("rready", 64'(RREADY), 64'(busy && !ar_open));
        if (!busy && any) begin
          busy     = 1;
          ar_open  = 1;
          own_lsu  = win_lsu;
          last_lsu = win_lsu;
          m_addr   = win_lsu ? lsu_req_addr : ifu_req_addr;
          m_size   = win_lsu ? lsu_req_size : ifu_req_size;
          m_id     = win_lsu ? 4'd1 : 4'd0;
          m_prot   = win_lsu ? 3'b000 : 3'b100;
          acc_l    = win_lsu;
          acc_i    = !win_lsu;
        end else if (ar_open && ARREADY) begin
          ar_open = 0;
          rdly    = $urandom_range(0, 2);
        end else if (busy && !ar_open && RVALID) begin
          if (RID == oid && RLAST) begin
            busy = 0;
            if (own_lsu) begin
              p_lsu = 1; d_lsu = RDATA; e_lsu = (RRESP != 2'b00);
            end else begin
              p_ifu = 1; d_ifu = RDATA; e_ifu = (RRESP != 2'b00);
            end
          end else begin
            m_perr = 1;
          end
        end
      end
    end
    $display("*** SUMMARY: %0d compared / %0d mismatched ***",
             n_cmp, n_bad);
    $finish;
  end

endmodule
